// File: rtl/float_arb_pkg.sv
// Shared types and constants for the float unit arbiter.
// The request id is sized for the largest supported requester count (8).
package float_arb_pkg;

    localparam logic [31:0] FLOAT_ONE = 32'h3F80_0000;
    localparam int MAX_REQ = 8;

    typedef logic [$clog2(MAX_REQ)-1:0] req_id_t;

    typedef struct packed {
        logic    valid;
        req_id_t id;
    } arb_tag_t;

endpackage

// File: rtl/float_unit_arbiter_rr.sv
// Round-robin arbiter: combinational one-hot grant starting at the pointer,
// with the pointer advancing past the winner after each grant.
module rr_arbiter
    import float_arb_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant,
    output req_id_t            grant_id,
    output logic               grant_valid
);

    req_id_t            ptr_q;
    req_id_t            ptr_d;
    logic [NUM_REQ-1:0] rot;
    logic               found;
    int                 sel;

    // Rotate the request vector so the pointer sits at bit 0, then take the first set bit.
    always_comb begin
        rot   = NUM_REQ'({req, req} >> ptr_q);
        found = 1'b0;
        sel   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && rot[k]) begin
                found = 1'b1;
                sel   = int'(ptr_q) + k;
            end
        end
        if (sel >= NUM_REQ) begin
            sel = sel - NUM_REQ;
        end
        grant_valid = found & enable;
        grant       = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            grant[j] = grant_valid && (sel == j);
        end
        grant_id = req_id_t'(sel);
        ptr_d    = ptr_q;
        if (grant_valid) begin
            ptr_d = (sel == NUM_REQ - 1) ? '0 : req_id_t'(sel + 1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/float_unit_arbiter.sv
// Shares one fixed-latency float unit among NUM_REQ requesters with a tag pipe
// routing results back. Define FLOAT_ARB_CHECK_EN to enable tag/valid checking.
module float_unit_arbiter
    import float_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int LATENCY = 8,
    parameter int DATA_W  = 32
) (
    input  logic                      clk_in,
    input  logic                      rst_n_in,
    input  logic                      hold_in,
    input  logic [NUM_REQ-1:0]        req_valid_in,
    input  logic [NUM_REQ*DATA_W-1:0] req_a_in,
    input  logic [NUM_REQ*DATA_W-1:0] req_b_in,
    output logic [NUM_REQ-1:0]        req_ready_out,
    output logic                      op_valid_out,
    output logic [DATA_W-1:0]         op_a_out,
    output logic [DATA_W-1:0]         op_b_out,
    input  logic                      res_valid_in,
    input  logic [DATA_W-1:0]         res_data_in,
    output logic [NUM_REQ-1:0]        res_valid_out,
    output logic [DATA_W-1:0]         res_data_out,
    output logic                      busy_out,
    output logic                      err_out
);

    logic [NUM_REQ-1:0] grant;
    req_id_t            grant_id;
    logic               grant_valid;

    logic               op_valid_q, op_valid_d;
    logic [DATA_W-1:0]  op_a_q, op_a_d;
    logic [DATA_W-1:0]  op_b_q, op_b_d;
    req_id_t            op_id_q, op_id_d;

    arb_tag_t           tag_q [LATENCY];
    arb_tag_t           tag_d [LATENCY];
    arb_tag_t           head;
    logic               tag_any;

    logic [NUM_REQ-1:0] res_valid_q, res_valid_d;
    logic [DATA_W-1:0]  res_data_q, res_data_d;
    logic               err_q, err_d;
    logic               strobe;
    logic               mismatch;

    rr_arbiter #(
        .NUM_REQ(NUM_REQ)
    ) u_rr (
        .clk        (clk_in),
        .rst_n      (rst_n_in),
        .enable     (~hold_in & rst_n_in),
        .req        (req_valid_in),
        .grant      (grant),
        .grant_id   (grant_id),
        .grant_valid(grant_valid)
    );

    assign req_ready_out = grant;

    always_comb begin
        op_valid_d = grant_valid;
        op_id_d    = grant_valid ? grant_id : op_id_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                op_a_d = req_a_in[i*DATA_W +: DATA_W];
                op_b_d = req_b_in[i*DATA_W +: DATA_W];
            end
        end
    end

    // The tag pipe depth matches the unit latency so the head lines up with its result.
    always_comb begin
        tag_d[0] = '{valid: op_valid_q, id: op_id_q};
        for (int i = 1; i < LATENCY; i++) begin
            tag_d[i] = tag_q[i-1];
        end
        tag_any = 1'b0;
        for (int i = 0; i < LATENCY; i++) begin
            tag_any = tag_any | tag_q[i].valid;
        end
    end

    assign head = tag_q[LATENCY-1];

`ifdef FLOAT_ARB_CHECK_EN
    assign mismatch = head.valid != res_valid_in;
    assign strobe   = head.valid & res_valid_in;
`else
    logic unused_res_valid;
    assign unused_res_valid = res_valid_in;
    assign mismatch         = 1'b0;
    assign strobe           = head.valid;
`endif

    always_comb begin
        err_d       = err_q | mismatch;
        res_valid_d = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            res_valid_d[i] = strobe && (head.id == req_id_t'(i));
        end
        res_data_d = strobe ? res_data_in : res_data_q;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            op_valid_q  <= 1'b0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            op_id_q     <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                tag_q[i] <= '0;
            end
            res_valid_q <= '0;
            res_data_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            op_valid_q  <= op_valid_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            op_id_q     <= op_id_d;
            for (int i = 0; i < LATENCY; i++) begin
                tag_q[i] <= tag_d[i];
            end
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            err_q       <= err_d;
        end
    end

    assign op_valid_out  = op_valid_q;
    assign op_a_out      = op_a_q;
    assign op_b_out      = op_b_q;
    assign res_valid_out = res_valid_q;
    assign res_data_out  = res_data_q;
    assign busy_out      = op_valid_q | tag_any | (|res_valid_q);
    assign err_out       = err_q;

endmodule
